// File: rtl/hack_pkg.sv
// Shared types for the HACK boot/run controller.
// No logic; state encodings and the HACK data word width.
// Imported by hack_boot_ctrl and hack_bp_match.
package hack_pkg;

  // HACK instruction/data word width
  localparam int HACK_W = 16;

  // Controller states; encodings are visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_HI  = 3'd1,
    ST_LOAD_LO  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RST_HOLD = 3'd4,
    ST_HALTED   = 3'd5,
    ST_RUN      = 3'd6,
    ST_STEP     = 3'd7
  } state_t;

endpackage

// File: rtl/hack_bp_match.sv
// Breakpoint detector: PC compare masked during the first cycle of a run.
// Latency: bp_hit is combinational from pc_in; the mask is registered.
// Backpressure: none; pure observer of the CPU PC.
import hack_pkg::*;

module hack_bp_match (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_entry,
  input  logic              bp_en,
  input  logic [HACK_W-1:0] bp_addr,
  input  logic [HACK_W-1:0] pc_in,
  output logic              bp_hit
);

  logic first_run_cycle;

  // Mask is high only in the cycle right after the FSM enters RUN, so a run
  // resumed while parked on the breakpoint PC can execute that instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_run_cycle <= 1'b0;
    end else begin
      first_run_cycle <= run_entry;
    end
  end

  assign bp_hit = bp_en & (pc_in == bp_addr) & ~first_run_cycle;

endmodule

// File: rtl/hack_boot_ctrl.sv
// HACK run controller: byte-serial ROM loader, CPU reset hold, run/halt/step/breakpoint.
// Latency: one ROM write per 3 cycles minimum (hi byte, lo byte, write strobe).
// Backpressure: ld_ready low outside LOAD_HI/LOAD_LO; cpu_clk_en gates CPU progress.
import hack_pkg::*;

module hack_boot_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int RESET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [HACK_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  input  logic              run_cmd,
  input  logic              step_cmd,
  input  logic              halt_cmd,
  input  logic              bp_en,
  input  logic [HACK_W-1:0] bp_addr,
  input  logic [HACK_W-1:0] pc_in,
  output logic [2:0]        state_o,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_odd,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W + 1)'(1);
  localparam logic [7:0]        HOLD_INIT = 8'(RESET_CYCLES - 1);

  state_t     state;
  logic [7:0] hi_byte;
  logic       last_q;
  logic [7:0] hold_cnt;
  logic       ld_hs;
  logic       run_entry;
  logic       bp_hit;

  assign ld_ready  = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
  assign ld_hs     = ld_valid & ld_ready;
  assign state_o   = state;

  // RUN is entered from HALTED only when no higher-priority command is present
  assign run_entry = (state == ST_HALTED) & ~load_start & ~step_cmd & run_cmd;

  hack_bp_match u_bp_match (
    .clk       (clk),
    .reset     (reset),
    .run_entry (run_entry),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc_in     (pc_in),
    .bp_hit    (bp_hit)
  );

  // Clock enable is combinational so a halt or breakpoint stops the CPU
  // before the instruction at the current PC executes.
  always_comb begin
    cpu_clk_en = 1'b0;
    case (state)
      ST_STEP: cpu_clk_en = 1'b1;
      ST_RUN:  cpu_clk_en = ~halt_cmd & ~bp_hit;
      default: cpu_clk_en = 1'b0;
    endcase
  end

  // Main controller FSM; all outputs except ld_ready/cpu_clk_en are registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cpu_reset    <= 1'b1;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      words_loaded <= '0;
      err_odd      <= 1'b0;
      err_ovf      <= 1'b0;
      hi_byte      <= '0;
      last_q       <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          cpu_reset <= 1'b1;
          if (load_start) begin
            state        <= ST_LOAD_HI;
            rom_addr     <= '0;
            words_loaded <= '0;
            err_odd      <= 1'b0;
            err_ovf      <= 1'b0;
          end
        end
        ST_LOAD_HI: begin
          if (ld_hs) begin
            if (ld_last) begin
              // A program cannot end on a high byte; drop it and flag it
              err_odd <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              hi_byte <= ld_data;
              state   <= ST_LOAD_LO;
            end
          end
        end
        ST_LOAD_LO: begin
          if (ld_hs) begin
            rom_wdata <= {hi_byte, ld_data};
            last_q    <= ld_last;
            rom_we    <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          rom_addr     <= rom_addr + ADDR_ONE;
          words_loaded <= words_loaded + WORDS_ONE;
          if (last_q) begin
            state    <= ST_RST_HOLD;
            hold_cnt <= HOLD_INIT;
          end else if (rom_addr == ADDR_MAX) begin
            err_ovf  <= 1'b1;
            state    <= ST_RST_HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            state <= ST_LOAD_HI;
          end
        end
        ST_RST_HOLD: begin
          if (hold_cnt == 8'd0) begin
            state     <= ST_HALTED;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        ST_HALTED: begin
          if (load_start) begin
            state        <= ST_LOAD_HI;
            cpu_reset    <= 1'b1;
            rom_addr     <= '0;
            words_loaded <= '0;
            err_odd      <= 1'b0;
            err_ovf      <= 1'b0;
          end else if (step_cmd) begin
            state <= ST_STEP;
          end else if (run_cmd) begin
            state <= ST_RUN;
          end
        end
        ST_STEP: begin
          state <= ST_HALTED;
        end
        ST_RUN: begin
          if (halt_cmd || bp_hit) begin
            state <= ST_HALTED;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Self-checking bench for hack_boot_ctrl (ADDR_W=2 so ROM overflow is reachable).
// ROM writes are checked against a scoreboard queue; a simple PC model drives pc_in.
// Runs to a single summary line.
module tb_hack_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        rom_we;
  logic [1:0]  rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        cpu_clk_en;
  logic        run_cmd = 1'b0;
  logic        step_cmd = 1'b0;
  logic        halt_cmd = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0000;
  logic [15:0] pc = 16'h0000;
  logic [2:0]  state_o;
  logic [2:0]  words_loaded;
  logic        err_odd;
  logic        err_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int hold_seen = 0;
  int en_seen = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t sb_q[$];

  hack_boot_ctrl #(.ADDR_W(2), .RESET_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_wdata    (rom_wdata),
    .cpu_reset    (cpu_reset),
    .cpu_clk_en   (cpu_clk_en),
    .run_cmd      (run_cmd),
    .step_cmd     (step_cmd),
    .halt_cmd     (halt_cmd),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .pc_in        (pc),
    .state_o      (state_o),
    .words_loaded (words_loaded),
    .err_odd      (err_odd),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Minimal HACK PC: cleared while held in reset, advances on each enabled cycle
  always @(posedge clk) begin
    if (cpu_reset) pc <= 16'h0000;
    else if (cpu_clk_en) pc <= pc + 16'h0001;
  end

  // Scoreboard consumer and cycle counters, sampled mid-cycle
  always @(negedge clk) begin
    if (state_o == 3'd4 && cpu_reset) hold_seen++;
    if (cpu_clk_en) en_seen++;
    if (rom_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", {30'd0, rom_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {30'd0, rom_addr}, {30'd0, e.addr});
        check("wr_data", {16'd0, rom_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic push_wr(input logic [1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // sel: 0 load_start, 1 run, 2 step, 3 halt
  task automatic pulse_cmd(input int sel);
    @(posedge clk); #1;
    case (sel)
      0: load_start = 1'b1;
      1: run_cmd    = 1'b1;
      2: step_cmd   = 1'b1;
      default: halt_cmd = 1'b1;
    endcase
    @(posedge clk); #1;
    load_start = 1'b0;
    run_cmd    = 1'b0;
    step_cmd   = 1'b0;
    halt_cmd   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    ld_data  = d;
    ld_last  = last;
    ld_valid = 1'b1;
    @(negedge clk);
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ld_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {29'd0, state_o}, {29'd0, s});
  endtask

  task automatic check_reset_vals();
    check("rst_state",     {29'd0, state_o},      32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset},    32'd1);
    check("rst_clk_en",    {31'd0, cpu_clk_en},   32'd0);
    check("rst_ld_ready",  {31'd0, ld_ready},     32'd0);
    check("rst_rom_we",    {31'd0, rom_we},       32'd0);
    check("rst_rom_addr",  {30'd0, rom_addr},     32'd0);
    check("rst_rom_wdata", {16'd0, rom_wdata},    32'd0);
    check("rst_words",     {29'd0, words_loaded}, 32'd0);
    check("rst_err_odd",   {31'd0, err_odd},      32'd0);
    check("rst_err_ovf",   {31'd0, err_ovf},      32'd0);
  endtask

  initial begin
    int hb;
    int eb;
    int cnt;
    logic [15:0] pc_snap;
    logic [7:0] t1_bytes [4];
    t1_bytes[0] = 8'h00;
    t1_bytes[1] = 8'h05;
    t1_bytes[2] = 8'hEC;
    t1_bytes[3] = 8'h10;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;

    // Two-word program, then reset hold and HALTED
    hb = hold_seen;
    push_wr(2'd0, 16'h0005);
    push_wr(2'd1, 16'hEC10);
    pulse_cmd(0);
    for (int i = 0; i < 4; i++) send_byte(t1_bytes[i], i == 3);
    wait_state(3'd5, "t1_halted");
    check("t1_words",     {29'd0, words_loaded}, 32'd2);
    check("t1_err_odd",   {31'd0, err_odd},      32'd0);
    check("t1_err_ovf",   {31'd0, err_ovf},      32'd0);
    check("t1_hold_len",  hold_seen - hb,        32'd4);
    check("t1_cpu_reset", {31'd0, cpu_reset},    32'd0);
    check("t1_sb_empty",  sb_q.size(),           32'd0);

    // Odd byte count: one write, error, back to IDLE
    push_wr(2'd0, 16'h1234);
    pulse_cmd(0);
    check("t2_cpu_reset_load", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    @(negedge clk);
    check("t2_state",     {29'd0, state_o},      32'd0);
    check("t2_err_odd",   {31'd0, err_odd},      32'd1);
    check("t2_cpu_reset", {31'd0, cpu_reset},    32'd1);
    check("t2_words",     {29'd0, words_loaded}, 32'd1);

    // ROM overflow with ADDR_W=2
    for (int i = 0; i < 4; i++)
      push_wr(2'(i), {8'(8'h10 + 2*i), 8'(8'h11 + 2*i)});
    pulse_cmd(0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0);
    ld_data  = 8'h99;
    ld_valid = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ld_ready) cnt++;
    end
    ld_valid = 1'b0;
    check("t3_ld_ready_cnt", cnt,                   32'd0);
    check("t3_state",        {29'd0, state_o},      32'd5);
    check("t3_err_ovf",      {31'd0, err_ovf},      32'd1);
    check("t3_err_odd",      {31'd0, err_odd},      32'd0);
    check("t3_words",        {29'd0, words_loaded}, 32'd4);
    check("t3_rom_addr",     {30'd0, rom_addr},     32'd0);
    check("t3_sb_empty",     sb_q.size(),           32'd0);

    // Three single steps
    check("t4_pc_start", {16'd0, pc}, 32'd0);
    eb = en_seen;
    repeat (3) begin
      pulse_cmd(2);
      repeat (2) @(posedge clk);
    end
    #1;
    check("t4_en_cycles", en_seen - eb,     32'd3);
    check("t4_pc",        {16'd0, pc},      32'd3);
    check("t4_state",     {29'd0, state_o}, 32'd5);

    // Breakpoint at PC 5
    bp_en   = 1'b1;
    bp_addr = 16'd5;
    pulse_cmd(1);
    wait_state(3'd5, "t5_bp_halted");
    check("t5_pc_at_bp", {16'd0, pc}, 32'd5);
    repeat (3) @(negedge clk);
    check("t5_pc_stays", {16'd0, pc},         32'd5);
    check("t5_clk_en",   {31'd0, cpu_clk_en}, 32'd0);

    // Resume from the breakpoint PC; load_start is ignored while running
    pulse_cmd(1);
    pulse_cmd(0);
    @(negedge clk);
    check("t5_run_ignores_load", {29'd0, state_o}, 32'd6);
    pulse_cmd(3);
    @(negedge clk);
    check("t5_halt_state", {29'd0, state_o}, 32'd5);
    check("t5_pc_past_bp", {31'd0, (pc > 16'd5)}, 32'd1);
    pc_snap = pc;
    repeat (3) @(negedge clk);
    check("t5_pc_frozen", {16'd0, pc}, {16'd0, pc_snap});
    bp_en = 1'b0;

    // Reset asserted while in LOAD_LO of the second word
    push_wr(2'd0, 16'hABCD);
    pulse_cmd(0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h11, 1'b0);
    check("t6_in_load_lo", {29'd0, state_o}, 32'd2);
    ld_data  = 8'h22;
    ld_valid = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    check_reset_vals();
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    ld_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_state_after", {29'd0, state_o}, 32'd0);
    check("t6_sb_empty",    sb_q.size(),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
